// File: rtl/io_hilo_control_unit.sv
// Hardwired fetch/execute sequencer for the bus datapath: drives one-hot bus
// source strobes and register load strobes for in/out/mfhi/mflo/nop/halt.
module io_hilo_control_unit #(
  parameter logic [4:0] OP_IN   = 5'b10110,
  parameter logic [4:0] OP_OUT  = 5'b10111,
  parameter logic [4:0] OP_MFHI = 5'b11000,
  parameter logic [4:0] OP_MFLO = 5'b11001,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        ZLOout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InportOut,
  output logic [15:0] Rout,
  output logic        MARins,
  output logic        PCins,
  output logic        MDRins,
  output logic        IRins,
  output logic        ZLOins,
  output logic        Outports,
  output logic [15:0] Rin,
  output logic        incPC,
  output logic        MDRRead,
  output logic        halted,
  output logic [15:0] inst_count
);

  // T1W is the memory wait extension of T1; splitting it out lets PCins
  // fire only in the first T1 cycle so PC advances once per fetch.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T1W  = 3'd3,
    S_T2   = 3'd4,
    S_T3   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic [4:0]  opcode;
  logic [3:0]  ra;
  logic [15:0] ra_onehot;
  logic        unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign ra_onehot = 16'h0001 << ra;
  assign unused_ir = ^ir[22:0];

  assign inst_count = cnt_q;

  // Next-state and retired-instruction counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1W;
      S_T1W:  state_d = mem_ready ? S_T2 : S_T1W;
      S_T2:   state_d = S_T3;
      S_T3: begin
        cnt_d = cnt_q + 16'd1;
        if (opcode == OP_HALT) state_d = S_HALT;
        else if (run)          state_d = S_T0;
        else                   state_d = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode from registered state and IR only.
  always_comb begin
    PCout     = 1'b0;
    ZLOout    = 1'b0;
    MDRout    = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    InportOut = 1'b0;
    Rout      = '0;
    MARins    = 1'b0;
    PCins     = 1'b0;
    MDRins    = 1'b0;
    IRins     = 1'b0;
    ZLOins    = 1'b0;
    Outports  = 1'b0;
    Rin       = '0;
    incPC     = 1'b0;
    MDRRead   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARins = 1'b1;
        incPC  = 1'b1;
        ZLOins = 1'b1;
      end
      S_T1: begin
        ZLOout  = 1'b1;
        PCins   = 1'b1;
        MDRRead = 1'b1;
        MDRins  = 1'b1;
      end
      S_T1W: begin
        ZLOout  = 1'b1;
        MDRRead = 1'b1;
        MDRins  = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRins  = 1'b1;
      end
      S_T3: begin
        case (opcode)
          OP_IN: begin
            InportOut = 1'b1;
            Rin       = ra_onehot;
          end
          OP_OUT: begin
            Rout     = ra_onehot;
            Outports = 1'b1;
          end
          OP_MFHI: begin
            HIout = 1'b1;
            Rin   = ra_onehot;
          end
          OP_MFLO: begin
            LOout = 1'b1;
            Rin   = ra_onehot;
          end
          default: ;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_hilo_control_unit.sv
// Self-checking bench for io_hilo_control_unit: table-driven instructions,
// hand-written reset/run-drop/halt sequences and randomized instruction mixes.
module tb_io_hilo_control_unit;

  logic        clk = 1'b0;
  logic        clr, run, mem_ready;
  logic [31:0] ir;
  logic        PCout, ZLOout, MDRout, HIout, LOout, InportOut;
  logic [15:0] Rout, Rin, inst_count;
  logic        MARins, PCins, MDRins, IRins, ZLOins, Outports;
  logic        incPC, MDRRead, halted;

  io_hilo_control_unit dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .ZLOout(ZLOout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .InportOut(InportOut), .Rout(Rout),
    .MARins(MARins), .PCins(PCins), .MDRins(MDRins), .IRins(IRins),
    .ZLOins(ZLOins), .Outports(Outports), .Rin(Rin),
    .incPC(incPC), .MDRRead(MDRRead), .halted(halted),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic PCout, ZLOout, MDRout, HIout, LOout, InportOut;
    logic MARins, PCins, MDRins, IRins, ZLOins, Outports;
    logic incPC, MDRRead, halted;
    logic [15:0] Rout, Rin;
  } ov_t;

  typedef struct {
    logic [31:0] ir;
    int          waits;
    bit          run_next;
    ov_t         exp;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_cnt = '0;
  bit          at_t0 = 1'b0;
  vec_t        tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ov_t v_zero();
    ov_t e = '0;
    return e;
  endfunction

  function automatic ov_t v_t0();
    ov_t e = '0;
    e.PCout = 1'b1; e.MARins = 1'b1; e.incPC = 1'b1; e.ZLOins = 1'b1;
    return e;
  endfunction

  function automatic ov_t v_t1(input bit first);
    ov_t e = '0;
    e.ZLOout = 1'b1; e.MDRRead = 1'b1; e.MDRins = 1'b1; e.PCins = first;
    return e;
  endfunction

  function automatic ov_t v_t2();
    ov_t e = '0;
    e.MDRout = 1'b1; e.IRins = 1'b1;
    return e;
  endfunction

  function automatic ov_t v_halt();
    ov_t e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  function automatic ov_t mk(input bit hi, input bit lo, input bit inp, input bit outp,
                             input logic [15:0] rin, input logic [15:0] rout);
    ov_t e = '0;
    e.HIout = hi; e.LOout = lo; e.InportOut = inp; e.Outports = outp;
    e.Rin = rin; e.Rout = rout;
    return e;
  endfunction

  // Reference for the execute cycle: register-transfer meaning of each opcode.
  function automatic ov_t model_exec(input logic [31:0] iv);
    ov_t        e = '0;
    logic [4:0] op = iv[31:27];
    int         r  = int'(iv[26:23]);
    if (op == 5'b10110) begin e.InportOut = 1'b1; e.Rin[r] = 1'b1; end
    else if (op == 5'b10111) begin e.Outports = 1'b1; e.Rout[r] = 1'b1; end
    else if (op == 5'b11000) begin e.HIout = 1'b1; e.Rin[r] = 1'b1; end
    else if (op == 5'b11001) begin e.LOout = 1'b1; e.Rin[r] = 1'b1; end
    return e;
  endfunction

  task automatic check(input string nm, input ov_t e);
    ov_t a;
    a = {PCout, ZLOout, MDRout, HIout, LOout, InportOut, MARins, PCins, MDRins,
         IRins, ZLOins, Outports, incPC, MDRRead, halted, Rout, Rin};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s outputs: got %h want %h", nm, a, e);
    end
    total++;
    if (inst_count !== m_cnt) begin
      bad++;
      $display("FAIL %s inst_count: got %0d want %0d", nm, inst_count, m_cnt);
    end
    total++;
    if ($countones({PCout, ZLOout, MDRout, HIout, LOout, InportOut, Rout}) > 1) begin
      bad++;
      $display("FAIL %s bus_single: got %0d sources want <=1", nm,
               $countones({PCout, ZLOout, MDRout, HIout, LOout, InportOut, Rout}));
    end
  endtask

  task automatic ensure_t0();
    if (!at_t0) begin
      run = 1'b1;
      tick();
    end
  endtask

  // One full instruction starting in T0; leaves at_t0 set when the next
  // instruction issues without an idle cycle.
  task automatic do_instr(input logic [31:0] iv, input int waits, input bit run_next,
                          input bit drop, input ov_t exp3);
    bit is_halt;
    check("T0", v_t0());
    ir = iv;
    tick();
    check("T1_first", v_t1(1'b1));
    if (drop) run = 1'b0;
    for (int k = 0; k < waits; k++) begin
      mem_ready = 1'b0;
      tick();
      check("T1_wait", v_t1(1'b0));
    end
    mem_ready = 1'b1;
    tick();
    check("T2", v_t2());
    tick();
    check("T3", exp3);
    is_halt = (iv[31:27] == 5'b11011);
    if (!drop) run = run_next;
    mem_ready = 1'($urandom_range(0, 1));
    m_cnt = m_cnt + 16'd1;
    tick();
    at_t0 = 1'b0;
    if (is_halt) check("halt_entry", v_halt());
    else if (run) at_t0 = 1'b1;
    else check("idle_after", v_zero());
  endtask

  initial begin
    clr = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = '0;

    tbl[0] = '{ir: 32'hC2800000, waits: 0, run_next: 1'b0, exp: mk(1, 0, 0, 0, 16'h0020, 16'h0000)};
    tbl[1] = '{ir: 32'hB9800000, waits: 3, run_next: 1'b0, exp: mk(0, 0, 0, 1, 16'h0000, 16'h0008)};
    tbl[2] = '{ir: 32'hB3800000, waits: 0, run_next: 1'b1, exp: mk(0, 0, 1, 0, 16'h0080, 16'h0000)};
    tbl[3] = '{ir: 32'hC8000000, waits: 1, run_next: 1'b0, exp: mk(0, 1, 0, 0, 16'h0001, 16'h0000)};
    tbl[4] = '{ir: 32'h08000000, waits: 0, run_next: 1'b1, exp: mk(0, 0, 0, 0, 16'h0000, 16'h0000)};
    tbl[5] = '{ir: 32'hD0000000, waits: 2, run_next: 1'b0, exp: mk(0, 0, 0, 0, 16'h0000, 16'h0000)};

    tick();
    check("reset", v_zero());
    clr = 1'b1;
    tick();
    check("idle_run0", v_zero());
    tick();
    check("idle_run0_b", v_zero());

    foreach (tbl[i]) begin
      ensure_t0();
      do_instr(tbl[i].ir, tbl[i].waits, tbl[i].run_next, 1'b0, tbl[i].exp);
    end

    // Asynchronous clear in the middle of T1 wipes strobes and the counter.
    ensure_t0();
    check("pre_rst_T0", v_t0());
    ir = 32'hC2800000;
    mem_ready = 1'b0;
    tick();
    check("pre_rst_T1", v_t1(1'b1));
    #2 clr = 1'b0;
    m_cnt = '0;
    #1 check("async_rst", v_zero());
    run = 1'b0;
    tick();
    check("rst_held", v_zero());
    #2 clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_after_rst", v_zero());
    end
    at_t0 = 1'b0;

    // Randomized instruction mix against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] iv;
      int          sel;
      logic [4:0]  op;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: op = 5'b10110;
        1: op = 5'b10111;
        2: op = 5'b11000;
        3: op = 5'b11001;
        4: op = 5'b11010;
        default: begin
          int u;
          u = int'($urandom_range(0, 25));
          if (u > 21) u = u + 6;
          op = 5'(u);
        end
      endcase
      iv = {op, 4'($urandom_range(0, 15)), 23'($urandom)};
      ensure_t0();
      do_instr(iv, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), model_exec(iv));
    end

    // run dropped during T1: instruction completes, then idles.
    ensure_t0();
    do_instr(32'hC4800000, 2, 1'b1, 1'b1, mk(1, 0, 0, 0, 16'h0200, 16'h0000));
    tick();
    check("idle_after_drop", v_zero());

    // halt freezes until clr.
    ensure_t0();
    do_instr(32'hD8000000, 1, 1'b1, 1'b0, v_zero());
    for (int k = 0; k < 5; k++) begin
      run = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      check("halt_frozen", v_halt());
    end
    #2 clr = 1'b0;
    m_cnt = '0;
    #1 check("halt_clr", v_zero());
    run = 1'b0;
    #2 clr = 1'b1;
    tick();
    check("post_halt_idle", v_zero());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_hilo_control_unit.md
Name: io_hilo_control_unit

Overview:
- Hardwired control sequencer for the bus datapath.
- Runs the instruction fetch (PC to MAR, PC+1, memory read to MDR, MDR to IR) and then executes one of the register-transfer instructions: in, out, mfhi, mflo, nop, halt.
- Drives the datapath's one-hot out-select and in-select strobes directly, replacing hand-sequenced testbench stimulus.
- Sits between the IR and the datapath control inputs.

Parameters:
- OP_IN, 5'b10110, opcode for in Ra (Inport to Ra)
- OP_OUT, 5'b10111, opcode for out Ra (Ra to Outport)
- OP_MFHI, 5'b11000, opcode for mfhi Ra (HI to Ra)
- OP_MFLO, 5'b11001, opcode for mflo Ra (LO to Ra)
- OP_NOP, 5'b11010, opcode for nop
- OP_HALT, 5'b11011, opcode for halt

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- run  in  1  level; 1 permits instruction issue
- mem_ready  in  1  memory read data valid on MDR input
- ir  in  32  IR contents; opcode = ir[31:27], Ra = ir[26:23]
- PCout, ZLOout, MDRout, HIout, LOout, InportOut  out  1 each  bus source strobes
- Rout  out  16  one-hot GP register bus source
- MARins, PCins, MDRins, IRins, ZLOins, Outports  out  1 each  load strobes
- Rin  out  16  one-hot GP register load
- incPC, MDRRead  out  1 each  ALU increment select, MDR mux select (memory)
- halted  out  1  high in HALT state
- inst_count  out  16  retired instruction count

Behaviour:
- Reset (clr=0, asynchronous):
  - State goes to IDLE and inst_count to 0.
  - Every output is 0 immediately, including mid-instruction; no strobe may persist after clr falls.
- Outputs are Moore: decoded only from the registered state and ir, and never depend on run or mem_ready combinationally.
- At most one bus source strobe is high in any cycle, across PCout, ZLOout, MDRout, HIout, LOout, InportOut and all Rout bits.
- States and transitions:
  - IDLE: no strobes. Go to T0 when run=1.
  - T0: PCout=1, MARins=1, incPC=1, ZLOins=1. Go to T1.
  - T1: ZLOout=1, PCins=1, MDRRead=1, MDRins=1.
    - Stay in T1 while mem_ready=0 (wait states).
    - PCins is asserted only in the first T1 cycle, so PC increments exactly once per fetch.
    - MDRRead and MDRins are held in every T1 cycle.
    - Go to T2 on mem_ready=1.
  - T2: MDRout=1, IRins=1. Go to T3.
  - T3 (ir is now valid), decode on ir[31:27]:
    - OP_IN: InportOut=1, Rin[Ra]=1.
    - OP_OUT: Rout[Ra]=1, Outports=1.
    - OP_MFHI: HIout=1, Rin[Ra]=1.
    - OP_MFLO: LOout=1, Rin[Ra]=1.
    - OP_NOP, or any undefined opcode: no strobes.
    - OP_HALT: no strobes; next state is HALT.
    - Otherwise: go to T0 if run=1, else IDLE.
  - HALT: halted=1, no strobes. Only clr exits.
- run=0 mid-instruction: the current instruction completes through T3, then the block goes to IDLE. No partial instruction is ever abandoned.
- Latency: 4 cycles per instruction with mem_ready=1 throughout; each mem_ready=0 cycle in T1 adds one.
- inst_count:
  - Increments by 1 on every T3 exit, including nop, undefined opcodes and halt.
  - Wraps from 16'hFFFF to 0.
- Ra = 0..15 maps directly onto Rin/Rout bit index. Rin and Rout are all-zero outside T3.

Test Plan:
- Reset and idle: clr=0 mid-T1 with MDRRead=1 -> all outputs 0 in the same cycle, inst_count=0. Release clr with run=0 -> stays IDLE, no strobes.
- mfhi R5: run=1, mem_ready=1, ir=32'hC2800000 at T3 -> T0..T3 in 4 cycles. T3 shows HIout=1 and Rin=16'h0020. inst_count=1.
- out R3 with wait states: ir=32'hB9800000, mem_ready low for 3 cycles -> T1 lasts 4 cycles, PCins high only in the first. T3 shows Rout=16'h0008 and Outports=1.
- in R7 then mflo R0 back-to-back: ir=32'hB3800000 then 32'hC8000000 -> Rin=16'h0080 with InportOut, then Rin=16'h0001 with LOout. No idle cycle between them. inst_count=2.
- run dropped in T1: run 1 -> 0 during T1 -> instruction completes T2 and T3, then IDLE. Single-source bus check holds every cycle.
- halt and undefined: ir=32'hD8000000 -> HALT with halted=1, frozen until clr. Undefined opcode 5'b00001 -> T3 issues no strobes, inst_count still increments.
